datamem_dump_ctrl: RTL and testbench

DATAMEM_DUMP_CTRL -- requirements
Module: datamem_dump_ctrl

---
 rtl/datamem_dump_ctrl_pkg.sv | 21 ++
 rtl/datamem_dump_ctrl_word_to_byte_tx.sv | 55 +++++
 rtl/datamem_dump_ctrl.sv | 109 ++++++++++
 tb/tb_datamem_dump_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datamem_dump_ctrl_pkg.sv
// Shared definitions for the data-memory dump controller.
//   dump_state_t    : FSM state encoding (also exported for debug visibility)
//   BYTES_PER_WORD  : bytes serialized per data-memory word
//   UART_BYTE_W     : width of one UART byte
//   IDX_W           : width of the byte index inside a word
package datamem_dump_ctrl_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int UART_BYTE_W    = 8;
  localparam int IDX_W          = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_READ      = 3'd2,
    ST_LATCH     = 3'd3,
    ST_SEND      = 3'd4,
    ST_DONE      = 3'd5
  } dump_state_t;

endpackage

// File: rtl/datamem_dump_ctrl_word_to_byte_tx.sv
// word_to_byte_tx: holds one memory word and hands it to the UART one byte
// at a time, most significant byte first.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clear       : drop the held word and index (dump aborted)
//   load        : capture word and restart at the top byte
//   word        : word to capture when load is high
//   send        : controller is in its byte-sending phase
//   ready       : UART accepts the presented byte
//   byte_data   : byte currently presented (0 when not sending)
//   valid       : byte_data is valid
//   last_xfer   : the lowest byte is being accepted this cycle
//
// Handshake: a byte moves only on a cycle where valid and ready are both 1.
// While valid=1 and ready=0 the index does not move, so byte_data holds.
module word_to_byte_tx
  import datamem_dump_ctrl_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   load,
  input  logic [NB_DATA-1:0]     word,
  input  logic                   send,
  input  logic                   ready,
  output logic [UART_BYTE_W-1:0] byte_data,
  output logic                   valid,
  output logic                   last_xfer
);

  logic [NB_DATA-1:0] word_q;
  logic [IDX_W-1:0]   idx_q;
  logic               xfer;

  assign valid     = send;
  assign xfer      = send && ready;
  assign last_xfer = xfer && (idx_q == '0);
  // Gated so the UART data lines read 0 whenever nothing is offered.
  assign byte_data = send ? word_q[{idx_q, 3'b000} +: UART_BYTE_W] : '0;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= word;
      idx_q  <= IDX_W'(BYTES_PER_WORD - 1);
    end else if (xfer && (idx_q != '0)) begin
      idx_q <= idx_q - 1'b1;
    end
  end

endmodule

// File: rtl/datamem_dump_ctrl.sv
// datamem_dump_ctrl: stalls the pipeline, walks the whole data memory
// through the debug address port and streams every word to the UART,
// MSB first.
// Ports:
//   clock_i, reset_i    : clock, synchronous active-high reset
//   dump_start_i        : one-cycle dump request (honoured only in IDLE)
//   dump_abort_i        : return to IDLE on the next edge, no done pulse
//   pipeline_idle_i     : pipeline drained, memory port free
//   mem_data_i          : memory read data, one cycle after the address
//   tx_ready_i          : UART accepts tx_data_o
//   pipeline_stall_o    : holds the pipeline while busy
//   select_debug_o      : memory mux selects the debug address
//   mem_en_o            : memory enable for debug reads
//   addr_mem_debug_o    : debug read address
//   tx_data_o/tx_valid_o: byte offered to the UART
//   dump_busy_o         : any state other than IDLE
//   dump_done_o         : one-cycle pulse after the last byte is accepted
//   dump_state_o        : current FSM state for observation
module datamem_dump_ctrl
  import datamem_dump_ctrl_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   dump_start_i,
  input  logic                   dump_abort_i,
  input  logic                   pipeline_idle_i,
  input  logic [NB_DATA-1:0]     mem_data_i,
  input  logic                   tx_ready_i,
  output logic                   pipeline_stall_o,
  output logic                   select_debug_o,
  output logic                   mem_en_o,
  output logic [NB_ADDR-1:0]     addr_mem_debug_o,
  output logic [UART_BYTE_W-1:0] tx_data_o,
  output logic                   tx_valid_o,
  output logic                   dump_busy_o,
  output logic                   dump_done_o,
  output dump_state_t            dump_state_o
);

  localparam logic [NB_ADDR-1:0] ADDR_LAST = {NB_ADDR{1'b1}};

  dump_state_t        state_q;
  logic [NB_ADDR-1:0] addr_q;
  logic               last_xfer;

  // Abort (and reset) beat every transition, including a start in IDLE.
  always_ff @(posedge clock_i) begin
    if (reset_i || dump_abort_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dump_start_i) begin
            state_q <= ST_WAIT_IDLE;
            addr_q  <= '0;
          end
        end
        ST_WAIT_IDLE: if (pipeline_idle_i) state_q <= ST_READ;
        ST_READ:      state_q <= ST_LATCH;
        ST_LATCH:     state_q <= ST_SEND;
        ST_SEND: begin
          if (last_xfer) begin
            // The last word ends the dump; the address never wraps.
            if (addr_q == ADDR_LAST) begin
              state_q <= ST_DONE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          addr_q  <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore outputs decoded straight from the state register.
  assign pipeline_stall_o = (state_q != ST_IDLE);
  assign dump_busy_o      = (state_q != ST_IDLE);
  assign select_debug_o   = (state_q == ST_READ) || (state_q == ST_LATCH) ||
                            (state_q == ST_SEND);
  assign mem_en_o         = (state_q == ST_READ) || (state_q == ST_LATCH);
  assign addr_mem_debug_o = select_debug_o ? addr_q : '0;
  assign dump_done_o      = (state_q == ST_DONE);
  assign dump_state_o     = state_q;

  // Read data arrives during LATCH, so it is captured at the end of LATCH.
  word_to_byte_tx #(.NB_DATA(NB_DATA)) u_ser (
    .clk       (clock_i),
    .rst       (reset_i),
    .clear     (dump_abort_i),
    .load      (state_q == ST_LATCH),
    .word      (mem_data_i),
    .send      (state_q == ST_SEND),
    .ready     (tx_ready_i),
    .byte_data (tx_data_o),
    .valid     (tx_valid_o),
    .last_xfer (last_xfer)
  );

endmodule

// File: tb/tb_datamem_dump_ctrl.sv
// Self-checking bench for datamem_dump_ctrl: a cycle table for the basic
// state sequence, then full dumps, stalls, abort and reset sequences with
// every transferred byte checked against an expected queue.
module tb_datamem_dump_ctrl;
  import datamem_dump_ctrl_pkg::*;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 7;
  localparam int DEPTH   = 128;

  // ---------------- clock / reset ----------------
  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic               reset_i, dump_start_i, dump_abort_i, pipeline_idle_i;
  logic [NB_DATA-1:0] mem_data_i;
  logic               tx_ready_i;
  logic               pipeline_stall_o, select_debug_o, mem_en_o;
  logic [NB_ADDR-1:0] addr_mem_debug_o;
  logic [7:0]         tx_data_o;
  logic               tx_valid_o, dump_busy_o, dump_done_o;
  dump_state_t        dump_state_o;

  datamem_dump_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .dump_start_i     (dump_start_i),
    .dump_abort_i     (dump_abort_i),
    .pipeline_idle_i  (pipeline_idle_i),
    .mem_data_i       (mem_data_i),
    .tx_ready_i       (tx_ready_i),
    .pipeline_stall_o (pipeline_stall_o),
    .select_debug_o   (select_debug_o),
    .mem_en_o         (mem_en_o),
    .addr_mem_debug_o (addr_mem_debug_o),
    .tx_data_o        (tx_data_o),
    .tx_valid_o       (tx_valid_o),
    .dump_busy_o      (dump_busy_o),
    .dump_done_o      (dump_done_o),
    .dump_state_o     (dump_state_o)
  );

  // ---------------- memory model: 1-cycle read latency ----------------
  logic [NB_DATA-1:0] mem [0:DEPTH-1];
  initial mem_data_i = '0;
  always @(posedge clock_i) if (mem_en_o) mem_data_i <= mem[addr_mem_debug_o];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [20:0] outs();
    return {pipeline_stall_o, select_debug_o, mem_en_o, tx_valid_o, dump_busy_o,
            dump_done_o, addr_mem_debug_o, tx_data_o};
  endfunction

  function automatic logic [20:0] mk(input logic stall, sel, men, vld, busy, done,
                                     input logic [6:0] addr, input logic [7:0] data);
    return {stall, sel, men, vld, busy, done, addr, data};
  endfunction

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  bit         sb_on = 1'b0;
  int         done_cnt = 0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clock_i) begin
    if (sb_on) begin
      if (dump_done_o) done_cnt++;
      if (prev_valid && !prev_ready && tx_valid_o) check("tx_hold", tx_data_o, prev_data);
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_byte: got %0h expected no transfer (t=%0t)", tx_data_o, $time);
        end else begin
          check("tx_byte", tx_data_o, exp_q.pop_front());
        end
      end
    end
    prev_valid = tx_valid_o;
    prev_ready = tx_ready_i;
    prev_data  = tx_data_o;
  end

  task automatic push_all();
    for (int a = 0; a < DEPTH; a++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(mem[a][8*b +: 8]);
  endtask

  // mode 0: tx_ready always 1; mode 1: 1 cycle on, 2 off
  task automatic run_dump(input int mode, input bit repulse, input bit check_time);
    int first_read = -1;
    int done_at    = -1;
    push_all();
    done_cnt = 0;
    pipeline_idle_i = 1'b1;
    tx_ready_i = 1'b1;
    dump_start_i = 1'b1;
    step();
    dump_start_i = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      tx_ready_i   = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      dump_start_i = repulse && (i == 100 || i == 400);
      step();
      if (mem_en_o && first_read < 0) first_read = i;
      if (dump_done_o) begin
        done_at = i;
        break;
      end
    end
    dump_start_i = 1'b0;
    check("dump_finished", done_at >= 0, 1'b1);
    if (check_time) check("read_to_done", done_at - first_read, 768);
    tx_ready_i = 1'b1;
    repeat (4) step();
    check("done_pulses", done_cnt, 1);
    check("bytes_left", exp_q.size(), 0);
    check("idle_after_done", outs(), '0);
  endtask

  task automatic abort_at(input logic [6:0] at_addr, input bit use_reset);
    bit found = 1'b0;
    push_all();
    done_cnt = 0;
    tx_ready_i = 1'b1;
    pipeline_idle_i = 1'b1;
    dump_start_i = 1'b1;
    step();
    dump_start_i = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (addr_mem_debug_o == at_addr && tx_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_addr", found, 1'b1);
    step();  // top byte accepted, byte index now 2
    if (use_reset) reset_i = 1'b1;
    else dump_abort_i = 1'b1;
    step();
    reset_i = 1'b0;
    dump_abort_i = 1'b0;
    check(use_reset ? "after_reset" : "after_abort", outs(), '0);
    repeat (3) step();
    check("no_done_pulse", done_cnt, 0);
    check("stays_idle", outs(), '0);
    exp_q.delete();
    run_dump(0, 1'b0, 1'b1);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        start, abort, idle, ready;
    logic [20:0] exp;
  } vec_t;
  vec_t vec [12];

  initial begin
    reset_i = 1'b1; dump_start_i = 1'b0; dump_abort_i = 1'b0;
    pipeline_idle_i = 1'b0; tx_ready_i = 1'b0;
    for (int n = 0; n < DEPTH; n++) mem[n] = NB_DATA'(n);
    mem[0] = 32'hDEADBEEF;
    repeat (3) step();
    check("reset_outputs", outs(), '0);
    check("reset_state", dump_state_o, ST_IDLE);
    reset_i = 1'b0;

    //            start abort idle ready   stall sel men vld busy done addr data
    vec[0]  = '{0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 7'd0, 8'h00)};
    vec[1]  = '{1, 0, 0, 0, mk(1, 0, 0, 0, 1, 0, 7'd0, 8'h00)};
    vec[2]  = '{0, 0, 0, 0, mk(1, 0, 0, 0, 1, 0, 7'd0, 8'h00)};
    vec[3]  = '{0, 0, 1, 0, mk(1, 1, 1, 0, 1, 0, 7'd0, 8'h00)};
    vec[4]  = '{0, 0, 1, 0, mk(1, 1, 1, 0, 1, 0, 7'd0, 8'h00)};
    vec[5]  = '{0, 0, 1, 0, mk(1, 1, 0, 1, 1, 0, 7'd0, 8'hDE)};
    vec[6]  = '{0, 0, 1, 0, mk(1, 1, 0, 1, 1, 0, 7'd0, 8'hDE)};
    vec[7]  = '{0, 0, 1, 1, mk(1, 1, 0, 1, 1, 0, 7'd0, 8'hAD)};
    vec[8]  = '{0, 0, 1, 1, mk(1, 1, 0, 1, 1, 0, 7'd0, 8'hBE)};
    vec[9]  = '{0, 1, 1, 1, mk(0, 0, 0, 0, 0, 0, 7'd0, 8'h00)};
    vec[10] = '{1, 1, 1, 0, mk(0, 0, 0, 0, 0, 0, 7'd0, 8'h00)};
    vec[11] = '{0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 7'd0, 8'h00)};
    for (int v = 0; v < 12; v++) begin
      dump_start_i    = vec[v].start;
      dump_abort_i    = vec[v].abort;
      pipeline_idle_i = vec[v].idle;
      tx_ready_i      = vec[v].ready;
      step();
      check($sformatf("table_%0d", v), outs(), vec[v].exp);
    end
    dump_start_i = 1'b0; dump_abort_i = 1'b0;

    sb_on = 1'b1;

    // Full dump of word[n]=n, then again with start re-pulsed while busy.
    mem[0] = '0;
    run_dump(0, 1'b0, 1'b1);
    run_dump(0, 1'b1, 1'b1);

    // Back-pressured dump with a distinctive first word.
    mem[0] = 32'hDEADBEEF;
    run_dump(1, 1'b0, 1'b0);
    mem[0] = '0;

    // Pipeline not idle for 10 cycles: stalled, no debug select, no read.
    pipeline_idle_i = 1'b0;
    dump_start_i = 1'b1;
    step();
    dump_start_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("wait_idle", {pipeline_stall_o, select_debug_o, mem_en_o}, 3'b100);
      step();
    end
    pipeline_idle_i = 1'b1;
    step();
    check("first_read", {pipeline_stall_o, select_debug_o, mem_en_o, addr_mem_debug_o},
          {3'b111, 7'd0});
    dump_abort_i = 1'b1;
    step();
    dump_abort_i = 1'b0;
    check("abort_from_read", outs(), '0);

    abort_at(7'd5, 1'b0);
    abort_at(7'h40, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
